// File: rtl/coef_bank_if.sv
// Coefficient bank bus: random-access write port, stream command and the
// valid/ready output stream toward the systolic-array row feeder.
// COEF_BANK_PARALLEL_OUT_EN adds the flat parallel view of the bank (par_data).
interface coef_bank_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int REPEAT_WIDTH = 4
);
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    clear;
    logic                    start;
    logic [REPEAT_WIDTH-1:0] repeat_cnt;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic                    busy;
    logic                    bank_full;
    logic                    done;
`ifdef COEF_BANK_PARALLEL_OUT_EN
    logic [DEPTH*DATA_WIDTH-1:0] par_data;
`endif

    // Host / consumer side
    modport master (
        output wr_en, wr_addr, wr_data, clear, start, repeat_cnt, out_ready,
        input  out_data, out_valid, out_last, busy, bank_full, done
`ifdef COEF_BANK_PARALLEL_OUT_EN
        , input par_data
`endif
    );

    // Bank side
    modport slave (
        input  wr_en, wr_addr, wr_data, clear, start, repeat_cnt, out_ready,
        output out_data, out_valid, out_last, busy, bank_full, done
`ifdef COEF_BANK_PARALLEL_OUT_EN
        , output par_data
`endif
    );
endinterface

// File: rtl/coef_bank_streamer.sv
// Coefficient bank with load tracking that streams its whole contents, in
// address order, a programmable number of passes per start command.
// Optional macro COEF_BANK_PARALLEL_OUT_EN exposes the bank as par_data.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | bank open for writes/clear, waiting for start with full bank
// S_STREAM | bank frozen, presenting entry[rd_ptr] with out_valid high
// S_DONE   | one-cycle done pulse after the final transfer, bank open
module coef_bank_streamer #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int REPEAT_WIDTH = 4
) (
    input logic        clk,
    input logic        reset,
    coef_bank_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   entry_q [DEPTH];
    logic [DEPTH-1:0]        valid_q;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [REPEAT_WIDTH-1:0] pass_q, pass_d;
    logic [REPEAT_WIDTH-1:0] count_q, count_d;

    logic bank_open;
    logic wr_hit;
    logic full;

    assign bank_open = (state_q != S_STREAM);
    assign wr_hit    = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_W);
    assign full      = &valid_q;

    // Bank storage and load bitmap; clear beats a same-cycle write, and the
    // bank is frozen while streaming so held data stays stable under stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (bank_open) begin
            if (bus.clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    entry_q[i] <= '0;
                end
                valid_q <= '0;
            end else if (wr_hit) begin
                entry_q[bus.wr_addr] <= bus.wr_data;
                valid_q[bus.wr_addr] <= 1'b1;
            end
        end
    end

    // FSM and stream pointer registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            pass_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            pass_q   <= pass_d;
            count_q  <= count_d;
        end
    end

    // Next-state: start acceptance, per-transfer pointer advance, pass wrap
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        pass_d   = pass_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && full) begin
                    count_d  = (bus.repeat_cnt == '0) ? REPEAT_WIDTH'(1)
                                                      : bus.repeat_cnt;
                    rd_ptr_d = '0;
                    pass_d   = '0;
                    state_d  = S_STREAM;
                end
            end
            S_STREAM: begin
                if (bus.out_ready) begin
                    if (rd_ptr_q == LAST_PTR) begin
                        rd_ptr_d = '0;
                        pass_d   = pass_q + REPEAT_WIDTH'(1);
                        if (pass_q + REPEAT_WIDTH'(1) == count_q) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stream outputs; out_data is forced to zero outside STREAM
    always_comb begin
        bus.out_valid = (state_q == S_STREAM);
        bus.busy      = (state_q == S_STREAM);
        bus.done      = (state_q == S_DONE);
        bus.bank_full = full;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        if (state_q == S_STREAM) begin
            bus.out_data = entry_q[rd_ptr_q];
            bus.out_last = (rd_ptr_q == LAST_PTR) &&
                           (pass_q == count_q - REPEAT_WIDTH'(1));
        end
    end

`ifdef COEF_BANK_PARALLEL_OUT_EN
    // Flat view of the bank registers, entry i at [i*DATA_WIDTH +: DATA_WIDTH]
    always_comb begin
        bus.par_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.par_data[i*DATA_WIDTH +: DATA_WIDTH] = entry_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_coef_bank_streamer.sv
// Randomised bench for coef_bank_streamer against an array/queue model of
// the bank and the expected stream sequence.
module tb_coef_bank_streamer;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int RW    = 4;

    logic clk;
    logic reset;

    int n_checks;
    int n_pass;

    logic [DW-1:0] model_mem [DEPTH];
    bit            model_valid [DEPTH];

    coef_bank_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .REPEAT_WIDTH(RW)) bus ();

    coef_bank_streamer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .REPEAT_WIDTH(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_full();
        bit f;
        f = 1'b1;
        for (int i = 0; i < DEPTH; i++) f = f & model_valid[i];
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = '0;
            model_valid[i] = 1'b0;
        end
    endtask

    // Idle-time write applied to both the DUT and the model
    task automatic do_write(input int addr, input logic [DW-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_data = data;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        if (addr < DEPTH) begin
            model_mem[addr]   = data;
            model_valid[addr] = 1'b1;
        end
    endtask

    // Issue start and follow the whole stream against the expected sequence
    task automatic run_stream(input int rc, input bit rand_ready, input bit interfere);
        logic [DW-1:0] exp_q[$];
        int passes, total, idx, cyc;
        passes = (rc == 0) ? 1 : rc;
        total  = passes * DEPTH;
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < DEPTH; i++) exp_q.push_back(model_mem[i]);
        bus.repeat_cnt = RW'(rc);
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.repeat_cnt = RW'($urandom);
        idx = 0;
        cyc = 0;
        while (idx < total && cyc < total * 8 + 20) begin
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (interfere) begin
                bus.wr_en   = 1'($urandom_range(0, 1));
                bus.wr_addr = AW'($urandom);
                bus.wr_data = DW'($urandom);
                bus.clear   = ($urandom_range(0, 3) == 0);
                bus.start   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                $display("FAIL stream_flags idx=%0d valid=%b busy=%b done=%b required 1/1/0",
                         idx, bus.out_valid, bus.busy, bus.done);
            end else n_pass++;
            n_checks++;
            if (bus.out_data !== exp_q[idx]) begin
                $display("FAIL stream_data idx=%0d got=%h required=%h", idx, bus.out_data, exp_q[idx]);
            end else n_pass++;
            n_checks++;
            if (bus.out_last !== (idx == total - 1)) begin
                $display("FAIL stream_last idx=%0d got=%b required=%b", idx, bus.out_last, (idx == total - 1));
            end else n_pass++;
            if (bus.out_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.wr_en     = 1'b0;
        bus.clear     = 1'b0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        n_checks++;
        if (idx != total) begin
            $display("FAIL stream_count transfers=%0d required=%0d", idx, total);
        end else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL done_pulse done=%b valid=%b busy=%b required 1/0/0",
                     bus.done, bus.out_valid, bus.busy);
        end else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL done_width done=%b busy=%b required 0/0", bus.done, bus.busy);
        end else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic check_full(input string tag);
        @(negedge clk);
        n_checks++;
        if (bus.bank_full !== model_full()) begin
            $display("FAIL %s bank_full got=%b required=%b", tag, bus.bank_full, model_full());
        end else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.bank_full !== 1'b0 || bus.out_data !== '0) begin
            $display("FAIL reset_state valid=%b last=%b busy=%b done=%b full=%b data=%h required all 0",
                     bus.out_valid, bus.out_last, bus.busy, bus.done, bus.bank_full, bus.out_data);
        end else n_pass++;
`ifdef COEF_BANK_PARALLEL_OUT_EN
        n_checks++;
        if (bus.par_data !== '0) $display("FAIL reset_par got=%h required=0", bus.par_data);
        else n_pass++;
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < DEPTH; i++) do_write(i, DW'(8'h10 + i));
        check_full("basic_full");
        run_stream(1, 1'b0, 1'b0);
    endtask

    task automatic test_partial_start();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_clear();
        for (int i = DEPTH - 2; i >= 0; i--) do_write(i, DW'($urandom));
        check_full("partial_full");
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                $display("FAIL partial_ignored valid=%b busy=%b required 0/0", bus.out_valid, bus.busy);
            end else n_pass++;
            @(posedge clk); #1;
        end
        do_write(DEPTH - 1, DW'($urandom));
        check_full("partial_complete");
        run_stream(1, 1'b0, 1'b0);
    endtask

    task automatic test_repeat();
        for (int i = 0; i < DEPTH; i++) do_write(i, DW'(8'h10 + i));
        run_stream(0, 1'b0, 1'b0);
        run_stream(3, 1'b0, 1'b0);
        // restream without reload, random count
        run_stream($urandom_range(2, 5), 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < DEPTH; i++) do_write(i, DW'($urandom));
        run_stream(1, 1'b1, 1'b1);
        run_stream(2, 1'b1, 1'b1);
        check_full("stall_full_kept");
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < DEPTH; i++) do_write(i, DW'($urandom));
        bus.out_ready  = 1'b1;
        bus.repeat_cnt = RW'(1);
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (bus.out_data !== model_mem[4] || bus.out_valid !== 1'b1) begin
            $display("FAIL midreset_elem4 data=%h valid=%b required %h/1", bus.out_data, bus.out_valid, model_mem[4]);
        end else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_clear();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.bank_full !== 1'b0 || bus.done !== 1'b0) begin
                $display("FAIL midreset_state valid=%b busy=%b full=%b done=%b required 0/0/0/0",
                         bus.out_valid, bus.busy, bus.bank_full, bus.done);
            end else n_pass++;
            @(posedge clk); #1;
        end
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL midreset_start valid=%b required 0", bus.out_valid);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_clear_write();
        for (int i = 0; i < DEPTH; i++) do_write(i, DW'($urandom_range(1, 255)));
        check_full("cw_full");
        bus.clear   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(3);
        bus.wr_data = 8'h5A;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        bus.wr_en = 1'b0;
        model_clear();
        check_full("cw_cleared");
`ifdef COEF_BANK_PARALLEL_OUT_EN
        @(negedge clk);
        n_checks++;
        if (bus.par_data !== '0) $display("FAIL cw_par_zero got=%h required=0", bus.par_data);
        else n_pass++;
        @(posedge clk); #1;
        do_write(2, 8'hAB);
        @(negedge clk);
        n_checks++;
        if (bus.par_data[23:16] !== 8'hAB || bus.par_data !== 64'h0000_0000_00AB_0000) begin
            $display("FAIL cw_par_entry2 got=%h required=0000000000ab0000", bus.par_data);
        end else n_pass++;
        @(posedge clk); #1;
`endif
        // write everything except entry 3: the clobbered write must have left it unloaded
        for (int i = 0; i < DEPTH; i++) if (i != 3) do_write(i, DW'($urandom));
        check_full("cw_entry3_unloaded");
        do_write(3, DW'($urandom));
        check_full("cw_refull");
        run_stream(1, 1'b1, 1'b0);
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        reset          = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.clear      = 1'b0;
        bus.start      = 1'b0;
        bus.repeat_cnt = '0;
        bus.out_ready  = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_partial_start();
        test_repeat();
        test_stall();
        test_mid_reset();
        test_clear_write();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
